// File: rtl/q_learn_ctrl_pkg.sv
// Shared widths, FSM encoding, job record and Q-table address composition
// for the Q-learning update sequencer.
package q_learn_pkg;
  localparam int STATE_W = 15;
  localparam int NUM_ACT = 9;
  localparam int Q_W     = 16;
  localparam int ACT_W   = 4;
  localparam int ADDR_W  = STATE_W + ACT_W;

  typedef enum logic [2:0] {IDLE, RD_Q, SCAN, LAST, WRITE} state_e;

  typedef struct packed {
    logic [STATE_W-1:0] state;
    logic [ACT_W-1:0]   action;
    logic [STATE_W-1:0] nxt;
    logic [Q_W-1:0]     reward;
    logic               terminal;
  } req_t;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [STATE_W-1:0] s,
                                                input logic [ACT_W-1:0]   a);
    return {s, a};
  endfunction
endpackage

// File: rtl/q_learn_ctrl_if.sv
// Job request, config, Q-table RAM and result signals of the update sequencer.
interface q_learn_ctrl_if;
  import q_learn_pkg::*;
  logic               cfg_we;
  logic [Q_W-1:0]     cfg_gamma;
  logic [Q_W-1:0]     cfg_alfa;
  logic               req_valid;
  logic               req_ready;
  logic [STATE_W-1:0] req_state;
  logic [ACT_W-1:0]   req_action;
  logic [STATE_W-1:0] req_next;
  logic [Q_W-1:0]     req_reward;
  logic               req_terminal;
  logic               mem_en;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [Q_W-1:0]     mem_wdata;
  logic [Q_W-1:0]     mem_rdata;
  logic               done;
  logic [Q_W-1:0]     q_new;
  logic [ACT_W-1:0]   best_action;

  modport slave (
    input  cfg_we, cfg_gamma, cfg_alfa, req_valid, req_state, req_action,
           req_next, req_reward, req_terminal, mem_rdata,
    output req_ready, mem_en, mem_we, mem_addr, mem_wdata, done, q_new, best_action
  );
  modport master (
    output cfg_we, cfg_gamma, cfg_alfa, req_valid, req_state, req_action,
           req_next, req_reward, req_terminal, mem_rdata,
    input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, done, q_new, best_action
  );
endinterface

// File: rtl/Q_updater.sv
// Combinational Q-value update: Q + alfa*(reward + gamma*max_Q - Q), W-bit wraparound.
module Q_updater #(
  parameter int W = 16
) (
  input  logic [W-1:0] Q,
  input  logic [W-1:0] max_Q,
  input  logic [W-1:0] gamma,
  input  logic [W-1:0] alfa,
  input  logic [W-1:0] reward,
  output logic [W-1:0] Q_new
);
  logic [W-1:0] w_td;
  assign w_td  = reward + gamma * max_Q - Q;
  assign Q_new = Q + alfa * w_td;
endmodule

// File: rtl/q_learn_ctrl_max_scan.sv
// Running unsigned max/argmax; first sample after clear is taken unconditionally,
// later ones only when strictly greater, so ties keep the lowest index.
module q_max_scan
  import q_learn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_vld,
  input  logic [ACT_W-1:0] i_idx,
  input  logic [Q_W-1:0]   i_val,
  output logic [Q_W-1:0]   o_max,
  output logic [ACT_W-1:0] o_arg
);
  logic r_have;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_have <= 1'b0;
      o_max  <= '0;
      o_arg  <= '0;
    end else if (i_clr) begin
      r_have <= 1'b0;
      o_max  <= '0;
      o_arg  <= '0;
    end else if (i_vld && (!r_have || i_val > o_max)) begin
      r_have <= 1'b1;
      o_max  <= i_val;
      o_arg  <= i_idx;
    end
  end
endmodule

// File: rtl/q_learn_ctrl.sv
// One tabular Q-learning update: read Q(s,a), scan row s' for max/argmax,
// write back the Q_updater result. RAM read data returns one cycle after the strobe.
module q_learn_ctrl
  import q_learn_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  q_learn_ctrl_if.slave bus
);
  state_e           r_state, w_next;
  req_t             r_req;
  logic [Q_W-1:0]   r_gamma, r_alfa, r_sg, r_sa, r_q, r_qnew;
  logic [ACT_W-1:0] r_idx, r_best;
  logic             w_accept, w_scan_vld, w_en, w_we, w_done;
  logic [ADDR_W-1:0] w_addr;
  logic [Q_W-1:0]   w_wdata, w_max, w_qnew;
  logic [ACT_W-1:0] w_arg;

  assign w_accept = (r_state == IDLE) && bus.req_valid;
  // Read data trails the address by one cycle, so sample k lands while idx = k+1.
  assign w_scan_vld = ((r_state == SCAN) && (r_idx != '0)) ||
                      ((r_state == LAST) && !r_req.terminal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gamma <= Q_W'(1);
      r_alfa  <= Q_W'(1);
    end else if (bus.cfg_we) begin
      r_gamma <= bus.cfg_gamma;
      r_alfa  <= bus.cfg_alfa;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req  <= '0;
      r_sg   <= '0;
      r_sa   <= '0;
      r_q    <= '0;
      r_idx  <= '0;
      r_qnew <= '0;
      r_best <= '0;
    end else begin
      if (w_accept) begin
        r_req <= '{state: bus.req_state, action: bus.req_action, nxt: bus.req_next,
                   reward: bus.req_reward, terminal: bus.req_terminal};
        r_sg  <= r_gamma;
        r_sa  <= r_alfa;
      end
      if (r_state == RD_Q) r_idx <= '0;
      else if (r_state == SCAN) r_idx <= r_idx + 4'd1;
      if (((r_state == SCAN) && (r_idx == '0)) || ((r_state == LAST) && r_req.terminal))
        r_q <= bus.mem_rdata;
      if (r_state == WRITE) begin
        r_qnew <= w_qnew;
        r_best <= w_arg;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_en    = 1'b0;
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    w_done  = 1'b0;
    case (r_state)
      IDLE:  if (bus.req_valid) w_next = RD_Q;
      RD_Q: begin
        w_en   = 1'b1;
        w_addr = mk_addr(r_req.state, r_req.action);
        w_next = r_req.terminal ? LAST : SCAN;
      end
      SCAN: begin
        w_en   = 1'b1;
        w_addr = mk_addr(r_req.nxt, r_idx);
        if (r_idx == ACT_W'(NUM_ACT - 1)) w_next = LAST;
      end
      LAST:  w_next = WRITE;
      WRITE: begin
        w_en    = 1'b1;
        w_we    = 1'b1;
        w_addr  = mk_addr(r_req.state, r_req.action);
        w_wdata = w_qnew;
        w_done  = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // A terminal job never feeds the scanner, so it stays at max 0 / arg 0.
  q_max_scan u_scan (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_vld (w_scan_vld),
    .i_idx (r_idx - 4'd1),
    .i_val (bus.mem_rdata),
    .o_max (w_max),
    .o_arg (w_arg)
  );

  Q_updater #(.W(Q_W)) u_upd (
    .Q      (r_q),
    .max_Q  (w_max),
    .gamma  (r_sg),
    .alfa   (r_sa),
    .reward (r_req.reward),
    .Q_new  (w_qnew)
  );

  assign bus.req_ready   = (r_state == IDLE) && rst_n;
  assign bus.mem_en      = w_en;
  assign bus.mem_we      = w_we;
  assign bus.mem_addr    = w_addr;
  assign bus.mem_wdata   = w_wdata;
  assign bus.done        = w_done;
  assign bus.q_new       = r_qnew;
  assign bus.best_action = r_best;
endmodule
